// File: rtl/wb_sram32_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM bridge.
//   state_e      : bridge FSM states
//   SRAM_AW      : SRAM word address width (256K words)
//   WB_AW        : Wishbone byte address width (1 MiB)
//   lane_map     : byte selects -> active-low lane enables {ub1, lb1, ub0, lb0}
//   sel_to_mask  : byte selects -> 32-bit data mask for read data
package wb_sram32_ctrl_pkg;

  localparam int SRAM_AW = 18;
  localparam int WB_AW   = 20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_ACK      = 3'd4
  } state_e;

  // sel[3] -> chip 1 upper byte, sel[0] -> chip 0 lower byte; lanes are active low.
  function automatic logic [3:0] lane_map(input logic [3:0] sel);
    return ~sel;
  endfunction

  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_sram32_ctrl.sv
// Wishbone classic slave (32-bit, 1 MiB) bridging to two 256Kx16 async SRAMs.
// Chip 1 carries data bits 31:16, chip 0 carries bits 15:0; both share the
// address, OE and WE lines. Pads are tristated in the top level, so data is
// split into sram_dat_o / sram_dat_i with sram_dat_oe as the drive enable.
//
// Ports:
//   clk_50mhz, reset (sync, active low)
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i[19:0], wb_sel_i[3:0], wb_dat_i[31:0]
//   wb_dat_o[31:0], wb_ack_o
//   sram_addr[17:0], sram_dat_o[31:0], sram_dat_i[31:0], sram_dat_oe
//   sram_oen, sram_wen, sram0_cen, sram1_cen, sram{0,1}_{ub,lb}n (all active low)
//   dbg_state_o : current FSM state
//
// Handshake: a request is cyc & stb held high until wb_ack_o; ack is a single
// cycle pulse. Dropping cyc or stb before ack aborts the access with no ack.
//
// Every output is a flop. The *_d values are computed from the next state so
// the external strobes change on the same edge as the state register.
module wb_sram32_ctrl
  import wb_sram32_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 clk_50mhz,
  input  logic                 reset,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [WB_AW-1:0]     wb_adr_i,
  input  logic [3:0]           wb_sel_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [31:0]          sram_dat_o,
  input  logic [31:0]          sram_dat_i,
  output logic                 sram_dat_oe,
  output logic                 sram_oen,
  output logic                 sram_wen,
  output logic                 sram0_cen,
  output logic                 sram1_cen,
  output logic                 sram0_ubn,
  output logic                 sram0_lbn,
  output logic                 sram1_ubn,
  output logic                 sram1_lbn,
  output state_e               dbg_state_o
);

  localparam logic [2:0] WS_LAST = 3'(WAIT_STATES);

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [3:0]           sel_q, sel_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [31:0]          wdat_q, wdat_d;
  logic [31:0]          rdat_q, rdat_d;
  logic [3:0]           lanes_q, lanes_d;
  logic                 cen0_q, cen0_d;
  logic                 cen1_q, cen1_d;
  logic                 oen_q, oen_d;
  logic                 wen_q, wen_d;
  logic                 oe_q, oe_d;
  logic                 ack_q, ack_d;

  logic                 req;
  logic                 active;
  logic                 unused_adr;

  // Byte offset bits are not meaningful for a word-wide slave.
  assign unused_adr = ^wb_adr_i[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    req     = wb_cyc_i & wb_stb_i;

    unique case (state_q)
      ST_IDLE: begin
        if (req && !ack_q) begin
          state_d = wb_we_i ? ST_WR_SETUP : ST_RD;
          we_d    = wb_we_i;
          sel_d   = wb_sel_i;
          addr_d  = wb_adr_i[WB_AW-1:2];
          wdat_d  = wb_dat_i;
          cnt_d   = 3'd0;
        end
      end
      ST_RD: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == WS_LAST) begin
          // OE has been low for the whole phase, so the pads are settled here.
          rdat_d  = sram_dat_i & sel_to_mask(sel_q);
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_WR_SETUP: begin
        state_d = req ? ST_WR_PULSE : ST_IDLE;
      end
      ST_WR_PULSE: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == WS_LAST) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered strobes follow the state being entered.
    active  = (state_d == ST_RD) || (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE);
    lanes_d = active ? lane_map(sel_d) : 4'hF;
    cen1_d  = ~(active & (sel_d[3] | sel_d[2]));
    cen0_d  = ~(active & (sel_d[1] | sel_d[0]));
    oen_d   = (state_d != ST_RD);
    wen_d   = (state_d != ST_WR_PULSE);
    // Data stays driven through ACK of a write to cover write hold time.
    oe_d    = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
              ((state_d == ST_ACK) && we_d);
    ack_d   = (state_d == ST_ACK);
  end

  always_ff @(posedge clk_50mhz) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      addr_q  <= '0;
      wdat_q  <= 32'h0;
      rdat_q  <= 32'h0;
      lanes_q <= 4'hF;
      cen0_q  <= 1'b1;
      cen1_q  <= 1'b1;
      oen_q   <= 1'b1;
      wen_q   <= 1'b1;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      lanes_q <= lanes_d;
      cen0_q  <= cen0_d;
      cen1_q  <= cen1_d;
      oen_q   <= oen_d;
      wen_q   <= wen_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
    end
  end

  assign wb_dat_o    = rdat_q;
  assign wb_ack_o    = ack_q;
  assign sram_addr   = addr_q;
  assign sram_dat_o  = wdat_q;
  assign sram_dat_oe = oe_q;
  assign sram_oen    = oen_q;
  assign sram_wen    = wen_q;
  assign sram0_cen   = cen0_q;
  assign sram1_cen   = cen1_q;
  assign sram1_ubn   = lanes_q[3];
  assign sram1_lbn   = lanes_q[2];
  assign sram0_ubn   = lanes_q[1];
  assign sram0_lbn   = lanes_q[0];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_sram32_ctrl.sv
// Behavioural 256Kx16 async SRAM. A write commits when nwe returns high after
// a low period during which ncs was low; read data is driven only while
// ncs and noe are both low.
module sram256_16 (
  input  logic        clk_i,
  input  logic [15:0] sram_dat_i,
  output logic [15:0] sram_dat_o,
  input  logic        sram_noe_i,
  input  logic        sram_nwe_i,
  input  logic        sram_ncs_i,
  input  logic [17:0] sram_addr_i,
  input  logic [1:0]  sram_bsel_i
);
  logic [15:0] mem [0:262143];
  bit          armed = 1'b0;
  logic [17:0] a_l;
  logic [15:0] d_l;
  logic [1:0]  b_l;

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
  end

  always @(posedge clk_i) begin
    if (!sram_nwe_i && !sram_ncs_i) begin
      armed = 1'b1;
      a_l   = sram_addr_i;
      d_l   = sram_dat_i;
      b_l   = sram_bsel_i;
    end else if (armed && sram_nwe_i) begin
      if (b_l[0]) mem[a_l][7:0]  = d_l[7:0];
      if (b_l[1]) mem[a_l][15:8] = d_l[15:8];
      armed = 1'b0;
    end
  end

  always_comb begin
    sram_dat_o = 'x;
    if (!sram_ncs_i && !sram_noe_i) begin
      sram_dat_o[7:0]  = sram_bsel_i[0] ? mem[sram_addr_i][7:0]  : 8'hxx;
      sram_dat_o[15:8] = sram_bsel_i[1] ? mem[sram_addr_i][15:8] : 8'hxx;
    end
  end
endmodule

module tb_wb_sram32_ctrl;
  import wb_sram32_ctrl_pkg::*;

  localparam int BUDGET = 30;

  logic clk;
  logic reset_n;

  logic        wb_cyc   [2];
  logic        wb_stb   [2];
  logic        wb_we    [2];
  logic [19:0] wb_adr   [2];
  logic [3:0]  wb_sel   [2];
  logic [31:0] wb_wdat  [2];
  logic [31:0] wb_rdat  [2];
  logic        wb_ack   [2];
  logic [17:0] sram_addr[2];
  logic [31:0] sram_wd  [2];
  logic        dat_oe   [2];
  logic        oen      [2];
  logic        wen      [2];
  logic        cen0     [2];
  logic        cen1     [2];
  logic        ub0      [2];
  logic        lb0      [2];
  logic        ub1      [2];
  logic        lb1      [2];
  state_e      dbg      [2];

  int n_vec = 0;
  int n_err = 0;

  // Reference memory: key = dut_index * 2^18 + word address; absent = 0.
  logic [31:0] ref_mem [int];

  // Bus monitors
  int          wen_run  [2];
  int          wen_last [2];
  logic [5:0]  act_seen [2];  // {cen1, cen0, ub1, lb1, ub0, lb0} seen active
  int          proto_bad[2];
  logic [17:0] prev_addr[2];
  logic        prev_wen [2];
  logic [17:0] last_addr[2];

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] rd_lo;
    logic [15:0] rd_hi;

    wb_sram32_ctrl #(.WAIT_STATES(2 * g)) u_dut (
      .clk_50mhz  (clk),
      .reset      (reset_n),
      .wb_cyc_i   (wb_cyc[g]),
      .wb_stb_i   (wb_stb[g]),
      .wb_we_i    (wb_we[g]),
      .wb_adr_i   (wb_adr[g]),
      .wb_sel_i   (wb_sel[g]),
      .wb_dat_i   (wb_wdat[g]),
      .wb_dat_o   (wb_rdat[g]),
      .wb_ack_o   (wb_ack[g]),
      .sram_addr  (sram_addr[g]),
      .sram_dat_o (sram_wd[g]),
      .sram_dat_i ({rd_hi, rd_lo}),
      .sram_dat_oe(dat_oe[g]),
      .sram_oen   (oen[g]),
      .sram_wen   (wen[g]),
      .sram0_cen  (cen0[g]),
      .sram1_cen  (cen1[g]),
      .sram0_ubn  (ub0[g]),
      .sram0_lbn  (lb0[g]),
      .sram1_ubn  (ub1[g]),
      .sram1_lbn  (lb1[g]),
      .dbg_state_o(dbg[g])
    );

    sram256_16 u_chip0 (
      .clk_i      (clk),
      .sram_dat_i (sram_wd[g][15:0]),
      .sram_dat_o (rd_lo),
      .sram_noe_i (oen[g]),
      .sram_nwe_i (wen[g]),
      .sram_ncs_i (cen0[g]),
      .sram_addr_i(sram_addr[g]),
      .sram_bsel_i({~ub0[g], ~lb0[g]})
    );

    sram256_16 u_chip1 (
      .clk_i      (clk),
      .sram_dat_i (sram_wd[g][31:16]),
      .sram_dat_o (rd_hi),
      .sram_noe_i (oen[g]),
      .sram_nwe_i (wen[g]),
      .sram_ncs_i (cen1[g]),
      .sram_addr_i(sram_addr[g]),
      .sram_bsel_i({~ub1[g], ~lb1[g]})
    );
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!wen[k]) begin
        wen_run[k]++;
      end else if (wen_run[k] != 0) begin
        wen_last[k] = wen_run[k];
        wen_run[k]  = 0;
      end
      act_seen[k] = act_seen[k] | {~cen1[k], ~cen0[k], ~ub1[k], ~lb1[k], ~ub0[k], ~lb0[k]};
      if (dat_oe[k] && !oen[k]) proto_bad[k]++;
      if (prev_wen[k] && !wen[k] && (sram_addr[k] != prev_addr[k])) proto_bad[k]++;
      prev_wen[k]  = wen[k];
      prev_addr[k] = sram_addr[k];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int k);
    return 2 * k;
  endfunction

  function automatic int key_of(input int k, input logic [19:0] adr);
    return k * 262144 + int'(adr[19:2]);
  endfunction

  function automatic logic [31:0] ref_read(input int k, input logic [19:0] adr, input logic [3:0] sel);
    logic [31:0] w;
    logic [31:0] r;
    w = ref_mem.exists(key_of(k, adr)) ? ref_mem[key_of(k, adr)] : 32'h0;
    r = 32'h0;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  task automatic ref_write(input int k, input logic [19:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] w;
    w = ref_mem.exists(key_of(k, adr)) ? ref_mem[key_of(k, adr)] : 32'h0;
    for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
    ref_mem[key_of(k, adr)] = w;
  endtask

  // One complete Wishbone transfer; lat = edges from the sampling edge to ack.
  task automatic wb_xfer(input int k, input bit we, input logic [19:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] rdat, output int lat);
    @(negedge clk);
    act_seen[k] = 6'h0;
    wb_cyc[k]  = 1'b1;
    wb_stb[k]  = 1'b1;
    wb_we[k]   = we;
    wb_adr[k]  = adr;
    wb_sel[k]  = sel;
    wb_wdat[k] = dat;
    lat  = 0;
    rdat = 32'h0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (wb_ack[k]) begin
        lat          = n;
        rdat         = wb_rdat[k];
        last_addr[k] = sram_addr[k];
        break;
      end
    end
    if (lat == 0) check_eq("ack_timeout", 32'd0, 32'd1);
    @(negedge clk);
    wb_cyc[k] = 1'b0;
    wb_stb[k] = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ack_one_cycle", {31'd0, wb_ack[k]}, 32'd0);
  endtask

  task automatic do_write(input int k, input logic [19:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] rd;
    int lat;
    wen_last[k] = 0;
    wb_xfer(k, 1'b1, adr, sel, dat, rd, lat);
    check_eq("wr_latency", lat, 3 + ws_of(k));
    check_eq("wr_addr", {14'd0, last_addr[k]}, {14'd0, adr[19:2]});
    check_eq("wen_pulse", wen_last[k], 1 + ws_of(k));
    ref_write(k, adr, sel, dat);
  endtask

  task automatic do_read(input int k, input logic [19:0] adr, input logic [3:0] sel);
    logic [31:0] rd;
    int lat;
    wb_xfer(k, 1'b0, adr, sel, 32'h0, rd, lat);
    check_eq("rd_latency", lat, 2 + ws_of(k));
    check_eq("rd_addr", {14'd0, last_addr[k]}, {14'd0, adr[19:2]});
    check_eq("rd_data", rd, ref_read(k, adr, sel));
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    check_eq({tag, "_strobes"},
             {23'd0, cen0[k], cen1[k], ub0[k], lb0[k], ub1[k], lb1[k], oen[k], wen[k], dat_oe[k]},
             {23'd0, 9'b111111110});
    check_eq({tag, "_ack"}, {31'd0, wb_ack[k]}, 32'd0);
    check_eq({tag, "_state"}, {29'd0, dbg[k]}, {29'd0, ST_IDLE});
  endtask

  initial begin
    logic [19:0] pool [8];
    for (int k = 0; k < 2; k++) begin
      wb_cyc[k] = 0; wb_stb[k] = 0; wb_we[k] = 0;
      wb_adr[k] = '0; wb_sel[k] = '0; wb_wdat[k] = '0;
      wen_run[k] = 0; wen_last[k] = 0; act_seen[k] = '0; proto_bad[k] = 0;
      prev_addr[k] = '0; prev_wen[k] = 1'b1; last_addr[k] = '0;
    end

    // Reset
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_idle_outputs(k, "reset");
      check_eq("reset_addr", {14'd0, sram_addr[k]}, 32'd0);
      check_eq("reset_wdat", sram_wd[k], 32'd0);
      check_eq("reset_rdat", wb_rdat[k], 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_idle_outputs(k, "post_reset");

    // Word write then read
    do_write(0, 20'h00010, 4'hF, 32'hDEADBEEF);
    do_read (0, 20'h00010, 4'hF);
    check_eq("word_addr", {14'd0, last_addr[0]}, 32'h4);

    // Byte write over an existing word
    do_write(0, 20'h00020, 4'hF, 32'h11223344);
    do_write(0, 20'h00020, 4'h1, 32'h000000AA);
    check_eq("byte_lanes", {26'd0, act_seen[0]}, {26'd0, 6'b010001});
    do_read (0, 20'h00020, 4'hF);
    check_eq("byte_merge", ref_read(0, 20'h00020, 4'hF), 32'h112233AA);

    // Top address, no wrap onto word 0
    do_write(0, 20'h00000, 4'hF, 32'h01020304);
    do_write(0, 20'hFFFFC, 4'hF, 32'h5A5AA5A5);
    check_eq("top_addr", {14'd0, last_addr[0]}, 32'h3FFFF);
    do_read (0, 20'hFFFFC, 4'hF);
    do_read (0, 20'h00000, 4'hF);
    do_read (0, 20'h00020, 4'h6);

    // Abort during the write pulse
    @(negedge clk);
    wb_cyc[0] = 1'b1; wb_stb[0] = 1'b1; wb_we[0] = 1'b1;
    wb_adr[0] = 20'h00040; wb_sel[0] = 4'hF; wb_wdat[0] = 32'hCAFEF00D;
    @(posedge clk); #1;
    check_eq("abort_setup_wen", {31'd0, wen[0]}, 32'd1);
    @(posedge clk); #1;
    check_eq("abort_pulse_wen", {31'd0, wen[0]}, 32'd0);
    @(negedge clk);
    wb_stb[0] = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs(0, "abort");
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("abort_no_ack", {31'd0, wb_ack[0]}, 32'd0);
    end
    wb_cyc[0] = 1'b0;
    ref_mem.delete(key_of(0, 20'h00040));
    do_read(0, 20'h00010, 4'hF);

    // Reset asserted in the middle of a write
    @(negedge clk);
    wb_cyc[0] = 1'b1; wb_stb[0] = 1'b1; wb_we[0] = 1'b1;
    wb_adr[0] = 20'h00044; wb_sel[0] = 4'hF; wb_wdat[0] = 32'h0BADF00D;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs(0, "mid_reset");
    check_eq("mid_reset_addr", {14'd0, sram_addr[0]}, 32'd0);
    @(negedge clk);
    wb_cyc[0] = 1'b0; wb_stb[0] = 1'b0;
    reset_n = 1'b1;
    ref_mem.delete(key_of(0, 20'h00044));
    do_read(0, 20'h00020, 4'hF);

    // Wait-state instance: directed then back-to-back reads
    do_write(1, 20'h00100, 4'hF, 32'h89ABCDEF);
    do_read (1, 20'h00100, 4'hF);
    do_read (1, 20'h00100, 4'hC);
    do_read (1, 20'h00100, 4'h3);

    // Randomized traffic on both instances over a small address pool
    for (int i = 0; i < 8; i++) pool[i] = 20'h00200 + 20'(4 * i);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 40; i++) begin
        logic [19:0] a;
        logic [3:0]  s;
        a = pool[$urandom_range(0, 7)];
        s = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 1) == 1) do_write(k, a, s, $urandom);
        else                           do_read (k, a, s);
      end
    end

    for (int k = 0; k < 2; k++) check_eq("protocol", proto_bad[k], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_sram32_ctrl.md
# wb_sram32_ctrl

Wishbone-to-asynchronous-SRAM bridge for the Spartan-3 board top level. It presents one 32-bit Wishbone classic slave (1 MiB, word-addressed) to the CPU bus. It drives two external 256K×16 SRAM chips that share address, OE and WE lines; chip 1 holds data bits 31:16 and chip 0 holds bits 15:0. The tristate data pads live in the top level; this block uses split in/out/enable data buses.

## Interface
Parameters:
- WAIT_STATES, 0, extra cycles added to the read-access and write-pulse phases (0..7)

Ports:
- clk_50mhz  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low reset
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  20  byte address; bits 1:0 ignored
- wb_sel_i  in  4  byte selects; sel[3] = bits 31:24
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid while wb_ack_o = 1
- wb_ack_o  out  1  one-cycle acknowledge
- sram_addr  out  18  word address = wb_adr_i[19:2]
- sram_dat_o  out  32  write data; bits 31:16 go to chip 1, bits 15:0 to chip 0
- sram_dat_i  in  32  read data from the pads
- sram_dat_oe  out  1  1 = top level drives the pads
- sram_oen, sram_wen  out  1  shared active-low output enable and write enable
- sram0_cen, sram1_cen  out  1  active-low chip enables
- sram0_ubn, sram0_lbn, sram1_ubn, sram1_lbn  out  1  active-low byte lane enables

## Operation
- Byte lane mapping:
  - sram1_ubn = ~sel[3]
  - sram1_lbn = ~sel[2]
  - sram0_ubn = ~sel[1]
  - sram0_lbn = ~sel[0]
- A chip's cen is low only if at least one of its lanes is selected.
- Reads assert all lanes that sel requests. Unselected bytes of wb_dat_o read as 0.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, ACK.
- IDLE:
  - Stays here while cyc&stb is low, or while wb_ack_o = 1.
  - On cyc&stb, registers addr, sel, data and we.
  - Goes to RD if reading, WR_SETUP if writing.
- RD:
  - oen = 0, cen and lanes active.
  - Lasts 1+WAIT_STATES cycles.
  - On its last cycle, latches sram_dat_i into wb_dat_o, then goes to ACK.
- WR_SETUP:
  - 1 cycle.
  - Address, cen, lanes and sram_dat_o valid; sram_dat_oe = 1; wen = 1.
- WR_PULSE:
  - wen = 0 for 1+WAIT_STATES cycles, then goes to ACK.
- ACK:
  - wb_ack_o = 1 for exactly one cycle.
  - wen = 1 and oen = 1.
  - Address, data and sram_dat_oe are held for write hold time.
  - cen is released.
  - Goes to IDLE.
- Abort: if cyc or stb drops in RD, WR_SETUP or WR_PULSE, the FSM goes to IDLE next cycle. All strobes deassert, no ack is issued, and memory contents are undefined only for the aborted word.
- sram_dat_oe and oen are never both active.
- wen never falls in the same cycle as an address change.

## Timing
- All outputs are registered.
- Reset values:
  - cen, ubn, lbn, oen, wen = 1
  - sram_dat_oe = 0
  - wb_ack_o = 0
  - sram_addr = 0, sram_dat_o = 0, wb_dat_o = 0
  - FSM in IDLE
- Reset asserted mid-access returns all outputs to reset values at the next edge.
- Read latency, from the edge sampling stb to ack high, is 2+WAIT_STATES cycles.
- Write latency is 3+WAIT_STATES cycles.
- Back-to-back transfers: one IDLE cycle follows each ACK. At WAIT_STATES = 0, throughput is one read per 3 cycles and one write per 4 cycles.
- With a 10 ns SRAM at 50 MHz, WAIT_STATES = 0 meets tAA and tWP.

## Structure
- Shared package holds:
  - state enum
  - SRAM_AW = 18 and WB_AW = 20
  - lane-mapping function: sel → {ub1, lb1, ub0, lb0}
- No sub-module is needed. The FSM with its registered output datapath is one module.
- The verification model is a behavioral 256K×16 SRAM, sram256_16, with:
  - ports clk_i, sram_dat_i, sram_dat_o, sram_noe_i, sram_nwe_i, sram_ncs_i, sram_addr_i, sram_bsel_i[1:0] (active-high byte selects)
  - write on the rising edge of nwe while ncs = 0, per byte select
  - read data returned while ncs = 0 and noe = 0
  - outputs X otherwise
- Two instances of sram256_16 are wired as above in the bench.

## Test plan
- Reset: hold reset = 0 for 5 cycles → all strobes high, wb_ack_o = 0, sram_dat_oe = 0; release → IDLE, no bus activity.
- Word write then read:
  - Write 0xDEADBEEF to 0x00010, sel = 1111.
  - Then read 0x00010 → wb_dat_o = 0xDEADBEEF.
  - Ack arrives 3 cycles after the write strobe and 2 cycles after the read strobe.
  - sram_addr = 0x00004.
- Byte write:
  - Write 0x000000AA to 0x00020 with sel = 0001, over a prior 0x11223344.
  - Read-back gives 0x112233AA.
  - Only sram0_lbn is low during the write; sram1_cen stays high.
- Top address:
  - Write and read 0x5A5AA5A5 at 0xFFFFC → sram_addr = 0x3FFFF.
  - 0x00000 is unchanged, confirming no wrap.
- Abort: drop stb during WR_PULSE → wen high next cycle, no ack, FSM back to IDLE. A subsequent read completes normally.
- WAIT_STATES = 2:
  - Read latency is 4 cycles and the wen-low pulse lasts 3 cycles.
  - Back-to-back reads each get exactly one ack.
